// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transaction splitter: in-flight split flags and
// the latched transaction fields.
package hyperbus_pkg;

   typedef struct packed {
      logic write;
      logic is_final;
   } split_flag_t;

   typedef struct packed {
      logic [31:0] address;
      logic        write;
      logic        burst_type;
      logic        address_space;
   } trans_struct;

   // Byte address of the next sub-transaction; words are 16 bits wide, wraps at 2^32.
   function automatic logic [31:0] next_address(input logic [31:0] addr,
                                                input logic [31:0] words);
      return addr + {words[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/hyperbus_flag_fifo.sv
// Synchronous FIFO holding one split_flag_t per issued sub-transaction.
module hyperbus_flag_fifo
   import hyperbus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  split_flag_t data_i,
   input  logic        pop_i,
   output split_flag_t data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);

   split_flag_t    mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_i && !empty_o) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= data_i;
   end

   assign data_o  = mem[rd_ptr[AW-1:0]];
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/hyperbus_trans_splitter.sv
// Splits long linear bursts into sub-transactions and merges their B / RX completions.
// Optional statistics outputs are enabled with HYPERBUS_SPLIT_STATS_EN.
module hyperbus_trans_splitter
   import hyperbus_pkg::*;
#(
   parameter int BURST_WIDTH = 12,
   parameter int NR_CS       = 2,
   parameter int FLAG_DEPTH  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [BURST_WIDTH-1:0] cfg_max_burst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [31:0]            in_address_i,
   input  logic [NR_CS-1:0]       in_cs_i,
   input  logic                   in_write_i,
   input  logic [BURST_WIDTH-1:0] in_burst_i,
   input  logic                   in_burst_type_i,
   input  logic                   in_address_space_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [31:0]            out_address_o,
   output logic [NR_CS-1:0]       out_cs_o,
   output logic                   out_write_o,
   output logic [BURST_WIDTH-1:0] out_burst_o,
   output logic                   out_burst_type_o,
   output logic                   out_address_space_o,
   input  logic                   b_valid_i,
   output logic                   b_ready_o,
   input  logic                   b_error_i,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   output logic                   b_error_o,
   input  logic                   rx_valid_i,
   input  logic                   rx_last_i,
   input  logic                   rx_error_i,
   input  logic                   rx_ready_i,
   output logic                   rx_valid_o,
   output logic                   rx_last_o,
   output logic                   rx_error_o,
   output logic                   rx_ready_o
`ifdef HYPERBUS_SPLIT_STATS_EN
   ,
   output logic [31:0]            split_count_o,
   output logic                   proto_err_o
`endif
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]             state_q;
   trans_struct            trans_q;
   logic [NR_CS-1:0]       cs_q;
   logic [BURST_WIDTH-1:0] remaining_q;
   logic [BURST_WIDTH-1:0] chunk_hold_q;
   logic                   hold_q;
   logic                   err_acc_q;

   logic [BURST_WIDTH-1:0] chunk;
   logic                   is_final;
   logic                   out_hs;
   split_flag_t            head;
   logic                   full, empty, pop, b_pop, rx_pop;
   logic                   b_head_ok, rx_head_ok;

   // A stalled offer keeps its chunk so a cfg change cannot alter out_burst_o mid-handshake.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      chunk = remaining_q;
      if (hold_q)
         chunk = chunk_hold_q;
      else if (trans_q.burst_type && !trans_q.address_space && cfg_max_burst_i != '0
               && remaining_q > cfg_max_burst_i)
         chunk = cfg_max_burst_i;
   end

   assign is_final    = (chunk == remaining_q);
   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_ISSUE) && !full;
   assign out_hs      = out_valid_o && out_ready_i;

   assign out_address_o       = trans_q.address;
   assign out_cs_o            = cs_q;
   assign out_write_o         = trans_q.write;
   assign out_burst_o         = chunk;
   assign out_burst_type_o    = trans_q.burst_type;
   assign out_address_space_o = trans_q.address_space;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         trans_q      <= '0;
         cs_q         <= '0;
         remaining_q  <= '0;
         chunk_hold_q <= '0;
         hold_q       <= 1'b0;
      end else begin
         hold_q       <= out_valid_o && !out_ready_i;
         chunk_hold_q <= chunk;
         case (state_q)
            ST_IDLE: if (in_valid_i) begin
               trans_q     <= '{address: in_address_i, write: in_write_i,
                                burst_type: in_burst_type_i, address_space: in_address_space_i};
               cs_q        <= in_cs_i;
               remaining_q <= in_burst_i;
               state_q     <= ST_ISSUE;
            end
            default: if (out_hs) begin
               if (is_final) begin
                  state_q <= ST_IDLE;
               end else begin
                  trans_q.address <= next_address(trans_q.address, 32'(chunk));
                  remaining_q     <= remaining_q - chunk;
               end
            end
         endcase
      end
   end

   hyperbus_flag_fifo #(.DEPTH(FLAG_DEPTH)) u_flag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (out_hs),
      .data_i  ('{write: trans_q.write, is_final: is_final}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign b_head_ok  = !empty && head.write;
   assign rx_head_ok = !empty && !head.write;

   // Responses with no matching head are swallowed: ready stays high, nothing forwarded.
   always_comb begin
      b_valid_o = 1'b0;
      b_ready_o = 1'b1;
      b_error_o = err_acc_q | b_error_i;
      b_pop     = 1'b0;
      if (b_head_ok) begin
         if (head.is_final) begin
            b_valid_o = b_valid_i;
            b_ready_o = b_ready_i;
            b_pop     = b_valid_i && b_ready_i;
         end else begin
            b_pop     = b_valid_i;
         end
      end
   end

   always_comb begin
      rx_valid_o = 1'b0;
      rx_last_o  = 1'b0;
      rx_error_o = 1'b0;
      rx_ready_o = 1'b1;
      rx_pop     = 1'b0;
      if (rx_head_ok) begin
         rx_valid_o = rx_valid_i;
         rx_last_o  = rx_last_i && head.is_final;
         rx_error_o = rx_error_i;
         rx_ready_o = rx_ready_i;
         rx_pop     = rx_valid_i && rx_ready_i && rx_last_i;
      end
   end

   assign pop = b_pop || rx_pop;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         err_acc_q <= 1'b0;
      else if (b_pop)
         err_acc_q <= head.is_final ? 1'b0 : (err_acc_q | b_error_i);
   end

`ifdef HYPERBUS_SPLIT_STATS_EN
   logic proto_violation;
   assign proto_violation = (b_valid_i && !b_head_ok) || (rx_valid_i && !rx_head_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         split_count_o <= '0;
         proto_err_o   <= 1'b0;
      end else begin
         if (out_hs && !is_final && split_count_o != '1)
            split_count_o <= split_count_o + 32'd1;
         if (proto_violation)
            proto_err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
// Directed plus randomized bench for hyperbus_trans_splitter against a chunk-list model.
module tb_hyperbus_trans_splitter;
   import hyperbus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] cfg_max_burst;
   logic        in_valid, in_ready;
   logic [31:0] in_address;
   logic [1:0]  in_cs;
   logic        in_write, in_burst_type, in_address_space;
   logic [11:0] in_burst;
   logic        out_valid, out_ready;
   logic [31:0] out_address;
   logic [1:0]  out_cs;
   logic        out_write, out_burst_type, out_address_space;
   logic [11:0] out_burst;
   logic        b_valid_i, b_ready_o, b_error_i, b_valid_o, b_ready_i, b_error_o;
   logic        rx_valid_i, rx_last_i, rx_error_i, rx_ready_i;
   logic        rx_valid_o, rx_last_o, rx_error_o, rx_ready_o;
`ifdef HYPERBUS_SPLIT_STATS_EN
   logic [31:0] split_count;
   logic        proto_err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_a[$];
   int          exp_l[$];

   always #5 clk = ~clk;

   hyperbus_trans_splitter dut (
      .clk_i(clk), .rst_i(rst), .cfg_max_burst_i(cfg_max_burst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_address_i(in_address),
      .in_cs_i(in_cs), .in_write_i(in_write), .in_burst_i(in_burst),
      .in_burst_type_i(in_burst_type), .in_address_space_i(in_address_space),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_address_o(out_address),
      .out_cs_o(out_cs), .out_write_o(out_write), .out_burst_o(out_burst),
      .out_burst_type_o(out_burst_type), .out_address_space_o(out_address_space),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_error_i(b_error_i),
      .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_error_o(b_error_o),
      .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i), .rx_error_i(rx_error_i),
      .rx_ready_i(rx_ready_i), .rx_valid_o(rx_valid_o), .rx_last_o(rx_last_o),
      .rx_error_o(rx_error_o), .rx_ready_o(rx_ready_o)
`ifdef HYPERBUS_SPLIT_STATS_EN
      , .split_count_o(split_count), .proto_err_o(proto_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: list of (address, length) sub-transactions implied by the splitting rules.
   task automatic model_chunks(input logic [31:0] addr, input int burst, input bit lin,
                               input bit reg_space, input int maxb);
      int          rem = burst;
      logic [31:0] a   = addr;
      int          c;
      exp_a.delete();
      exp_l.delete();
      do begin
         c = (!lin || reg_space || maxb == 0 || rem <= maxb) ? rem : maxb;
         exp_a.push_back(a);
         exp_l.push_back(c);
         a   = a + 32'(2 * c);
         rem = rem - c;
      end while (rem != 0);
   endtask

   task automatic drive_in(input logic [31:0] addr, input logic [1:0] cs, input logic wr,
                           input int burst, input logic lin, input logic reg_space, input int maxb);
      @(negedge clk);
      cfg_max_burst    = 12'(maxb);
      in_address       = addr;
      in_cs            = cs;
      in_write         = wr;
      in_burst         = 12'(burst);
      in_burst_type    = lin;
      in_address_space = reg_space;
      in_valid         = 1'b1;
      #1 check("in_ready_idle", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Full transaction: issue, check every chunk, then return all responses.
   task automatic run_trans(input logic [31:0] addr, input logic [1:0] cs, input logic wr,
                            input int burst, input logic lin, input logic reg_space,
                            input int maxb, input logic [7:0] err_mask);
      int   n;
      int   beats;
      logic exp_err = 1'b0;
      logic rerr;
      model_chunks(addr, burst, lin, reg_space, maxb);
      n = exp_a.size();
      drive_in(addr, cs, wr, burst, lin, reg_space, maxb);
      for (int k = 0; k < n; k++) begin
         out_ready = 1'b1;
         #1;
         check("out_valid", 32'(out_valid), 1);
         check("out_address", out_address, exp_a[k]);
         check("out_burst", 32'(out_burst), 32'(exp_l[k]));
         check("in_ready_busy", 32'(in_ready), 0);
         if (k == 0)
            check("out_fields", {27'd0, out_cs, out_write, out_burst_type, out_address_space},
                  {27'd0, cs, wr, lin, reg_space});
         @(negedge clk);
      end
      out_ready = 1'b0;
      #1;
      check("out_valid_done", 32'(out_valid), 0);
      check("in_ready_done", 32'(in_ready), 1);
      @(negedge clk);
      if (wr) begin
         for (int k = 0; k < n; k++) begin
            b_valid_i = 1'b1;
            b_ready_i = 1'b1;
            b_error_i = err_mask[k];
            exp_err   = exp_err | err_mask[k];
            #1;
            check("b_valid_o", 32'(b_valid_o), 32'(k == n - 1));
            check("b_ready_o", 32'(b_ready_o), 1);
            if (k == n - 1) check("b_error_o", 32'(b_error_o), 32'(exp_err));
            @(negedge clk);
            b_valid_i = 1'b0;
            b_error_i = 1'b0;
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            beats = (exp_l[k] == 0) ? 1 : exp_l[k];
            for (int j = 0; j < beats; j++) begin
               rerr       = 1'($urandom);
               rx_valid_i = 1'b1;
               rx_ready_i = 1'b1;
               rx_last_i  = (j == beats - 1);
               rx_error_i = rerr;
               #1;
               check("rx_valid_o", 32'(rx_valid_o), 1);
               check("rx_last_o", 32'(rx_last_o), 32'((k == n - 1) && (j == beats - 1)));
               check("rx_error_o", 32'(rx_error_o), 32'(rerr));
               @(negedge clk);
            end
         end
         rx_valid_i = 1'b0;
         rx_last_i  = 1'b0;
         rx_error_i = 1'b0;
      end
   endtask

   initial begin
      int burst, lower, maxb;
      rst = 1'b1; cfg_max_burst = '0; in_valid = 1'b0; in_address = '0; in_cs = '0;
      in_write = 1'b0; in_burst = '0; in_burst_type = 1'b0; in_address_space = 1'b0;
      out_ready = 1'b0; b_valid_i = 1'b0; b_error_i = 1'b0; b_ready_i = 1'b0;
      rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_error_i = 1'b0; rx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_b_valid", 32'(b_valid_o), 0);
      check("rst_out_address", out_address, 0);
      check("rst_out_burst", 32'(out_burst), 0);
`ifdef HYPERBUS_SPLIT_STATS_EN
      check("rst_proto_err", 32'(proto_err), 0);
`endif

      // Read beat with nothing in flight is swallowed.
      @(negedge clk);
      rx_valid_i = 1'b1; rx_last_i = 1'b1; rx_ready_i = 1'b0;
      #1;
      check("stray_rx_ready", 32'(rx_ready_o), 1);
      check("stray_rx_valid", 32'(rx_valid_o), 0);
      @(negedge clk);
      rx_valid_i = 1'b0; rx_last_i = 1'b0;

      run_trans(32'h100, 2'b01, 1'b1, 40, 1'b1, 1'b0, 16, 8'h00);
      run_trans(32'h100, 2'b01, 1'b1, 40, 1'b1, 1'b0, 16, 8'h02);
      run_trans(32'h100, 2'b01, 1'b1, 40, 1'b1, 1'b0, 16, 8'h00);
      run_trans(32'h400, 2'b10, 1'b0, 20, 1'b1, 1'b0, 8, 8'h00);
      run_trans(32'h800, 2'b01, 1'b0, 32, 1'b0, 1'b0, 8, 8'h00);
      run_trans(32'h004, 2'b10, 1'b1, 1, 1'b1, 1'b1, 8, 8'h01);
      run_trans(32'h040, 2'b01, 1'b1, 0, 1'b1, 1'b0, 8, 8'h00);
      run_trans(32'hFFFF_FFF0, 2'b01, 1'b0, 24, 1'b1, 1'b0, 8, 8'h00);

      // Stall mid-split, then fill the flag FIFO with responses withheld.
      model_chunks(32'h200, 80, 1'b1, 1'b0, 16);
      drive_in(32'h200, 2'b01, 1'b1, 80, 1'b1, 1'b0, 16);
      out_ready = 1'b1;
      #1 check("stall_c0_addr", out_address, exp_a[0]);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_valid", 32'(out_valid), 1);
         check("stall_addr", out_address, exp_a[1]);
         check("stall_burst", 32'(out_burst), 32'(exp_l[1]));
         check("stall_in_ready", 32'(in_ready), 0);
         @(negedge clk);
      end
      for (int k = 1; k < 4; k++) begin
         out_ready = 1'b1;
         #1 check("fill_addr", out_address, exp_a[k]);
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         check("full_valid", 32'(out_valid), 0);
         check("full_in_ready", 32'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b0;
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      #1 check("full_b_pop_valid", 32'(b_valid_o), 0);
      @(negedge clk);
      b_valid_i = 1'b0;
      #1;
      check("resume_valid", 32'(out_valid), 1);
      check("resume_addr", out_address, exp_a[4]);
      check("resume_burst", 32'(out_burst), 32'(exp_l[4]));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1 check("resume_in_ready", 32'(in_ready), 1);
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         b_valid_i = 1'b1;
         #1 check("stall_b_valid_o", 32'(b_valid_o), 32'(k == 4));
      end
      @(negedge clk);
      b_valid_i = 1'b0;

      // Reset while the second chunk is pending.
      model_chunks(32'h100, 40, 1'b1, 1'b0, 16);
      drive_in(32'h100, 2'b01, 1'b1, 40, 1'b1, 1'b0, 16);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1 check("pre_rst_addr", out_address, exp_a[1]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 1);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      b_valid_i = 1'b1; b_ready_i = 1'b1;
      #1;
      check("mid_rst_stray_b_valid", 32'(b_valid_o), 0);
      check("mid_rst_stray_b_ready", 32'(b_ready_o), 1);
      @(negedge clk);
      b_valid_i = 1'b0;
`ifdef HYPERBUS_SPLIT_STATS_EN
      #1 check("proto_err_sticky", 32'(proto_err), 1);
`endif
      run_trans(32'h300, 2'b10, 1'b0, 12, 1'b1, 1'b0, 8, 8'h00);

      // Randomized transactions, chunk count bounded by the FIFO depth.
      for (int t = 0; t < 24; t++) begin
         burst = $urandom_range(64, 1);
         lower = (burst + 3) / 4;
         maxb  = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(70, lower);
         run_trans($urandom, 2'($urandom_range(3, 1)), 1'($urandom), burst, 1'($urandom),
                   ($urandom_range(5, 0) == 0), maxb, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
